trace_buffer: RTL and testbench

- Circular trace store that sits directly downstream of the data packer.
- Captures each valid packed N-wide vector while tracing is high.
- When tracing is low, a drain request replays the stored vectors oldest-first over a valid/ready stream to the host readout path.
- Uses the same configId/configData byte-stream reconfiguration as the other instrumentation stages.

---
 rtl/trace_buffer.sv | 104 ++++++++++
 tb/tb_trace_buffer.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/trace_buffer.sv
// trace_buffer: circular capture store replaying entries oldest-first over valid/ready.
// Define TB_DROP_CNT_EN to build the saturating lost-capture counter behind dropped_count.
module trace_buffer #(
    parameter int N = 8,
    parameter int DATA_WIDTH = 32,
    parameter int TB_SIZE = 64,
    parameter logic [7:0] PERSONAL_CONFIG_ID = 8'd1,
    parameter logic [7:0] INITIAL_MODE = 8'h00
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              tracing,
    input  logic                              valid_in,
    input  logic [N-1:0][DATA_WIDTH-1:0]      vector_in,
    input  logic [7:0]                        configId,
    input  logic [7:0]                        configData,
    input  logic                              drain_start,
    input  logic                              out_ready,
    output logic [N-1:0][DATA_WIDTH-1:0]      vector_out,
    output logic                              valid_out,
    output logic                              last_out,
    output logic [$clog2(TB_SIZE+1)-1:0]      count,
    output logic                              overflow,
    output logic [15:0]                       dropped_count
);
    localparam int AW = $clog2(TB_SIZE);
    localparam int CW = $clog2(TB_SIZE + 1);
    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;
    state_t state, state_n;
    logic [AW-1:0] wr_ptr, rd_ptr, rd_addr;
    logic [7:0] mode, byte_counter;
    logic [N-1:0][DATA_WIDTH-1:0] mem [TB_SIZE];
    logic [N-1:0][DATA_WIDTH-1:0] mem_q;
    logic idle, full, cap, we, cfg, clr, accept, xfer, done, unused_mode;
    assign idle = state == IDLE;
    assign full = count == CW'(TB_SIZE);
    assign cap = idle && tracing && valid_in;
    assign we = cap && (!full || !mode[0]);
    assign cfg = idle && !tracing && configId == PERSONAL_CONFIG_ID;
    assign clr = cfg && byte_counter == 8'd1;
    assign accept = idle && !tracing && drain_start && count != '0 && !clr;
    assign xfer = state == DRAIN && valid_out && out_ready;
    assign done = xfer && count == CW'(1);
    assign unused_mode = ^mode[7:1];
    // Read address moves ahead on a transfer so the next entry is already registered.
    assign rd_addr = xfer ? rd_ptr + 1'b1 : rd_ptr;
    assign vector_out = valid_out ? mem_q : '0;
    assign last_out = valid_out && count == CW'(1);
    always_comb begin
        state_n = accept ? FETCH : state == FETCH ? DRAIN : done ? IDLE : state;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else state <= state_n;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
            overflow <= 1'b0;
            valid_out <= 1'b0;
            mode <= INITIAL_MODE;
            byte_counter <= '0;
        end else begin
            byte_counter <= configId != PERSONAL_CONFIG_ID ? 8'd0 :
                            cfg && byte_counter != 8'hFF ? byte_counter + 1'b1 : byte_counter;
            if (cfg && byte_counter == 8'd0) mode <= configData;
            if (clr) begin
                count <= '0;
                wr_ptr <= '0;
                overflow <= 1'b0;
            end
            if (cap && full) overflow <= 1'b1;
            if (we) wr_ptr <= wr_ptr + 1'b1;
            if (cap && !full) count <= count + 1'b1;
            if (accept) rd_ptr <= wr_ptr - count[AW-1:0];
            if (state == DRAIN && !valid_out) valid_out <= 1'b1;
            if (xfer) begin
                rd_ptr <= rd_ptr + 1'b1;
                count <= count - 1'b1;
            end
            if (done) begin
                valid_out <= 1'b0;
                overflow <= 1'b0;
            end
        end
    end
    always_ff @(posedge clk) begin
        if (we) mem[wr_ptr] <= vector_in;
        mem_q <= mem[rd_addr];
    end
`ifdef TB_DROP_CNT_EN
    logic [15:0] drop_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) drop_q <= '0;
        else if (clr || done) drop_q <= '0;
        else if (cap && full && drop_q != 16'hFFFF) drop_q <= drop_q + 1'b1;
    end
    assign dropped_count = drop_q;
`else
    assign dropped_count = '0;
`endif
endmodule

// File: tb/tb_trace_buffer.sv
// tb_trace_buffer: directed stimulus with a scoreboard queue checked by a negedge monitor.
module tb_trace_buffer;
    localparam int N = 2;
    localparam int DW = 8;
    localparam int TS = 4;
    localparam int CW = $clog2(TS + 1);
`ifdef TB_DROP_CNT_EN
    localparam int DROPS = 2;
`else
    localparam int DROPS = 0;
`endif
    typedef struct packed {
        logic [N-1:0][DW-1:0] v;
        logic l;
    } exp_t;
    logic clk = 1'b0, rst_n = 1'b0, tracing = 1'b0, valid_in = 1'b0;
    logic drain_start = 1'b0, out_ready = 1'b1;
    logic [N-1:0][DW-1:0] vector_in = '0;
    logic [N-1:0][DW-1:0] vector_out, held_v;
    logic [7:0] configId = 8'd0, configData = 8'd0;
    logic valid_out, last_out, overflow, held = 1'b0;
    logic [CW-1:0] count;
    logic [15:0] dropped_count;
    int checks = 0, fails = 0;
    exp_t q[$];
    exp_t e;
    trace_buffer #(.N(N), .DATA_WIDTH(DW), .TB_SIZE(TS)) dut (
        .clk(clk), .rst_n(rst_n), .tracing(tracing), .valid_in(valid_in),
        .vector_in(vector_in), .configId(configId), .configData(configData),
        .drain_start(drain_start), .out_ready(out_ready), .vector_out(vector_out),
        .valid_out(valid_out), .last_out(last_out), .count(count),
        .overflow(overflow), .dropped_count(dropped_count)
    );
    always #5 clk = ~clk;
    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask
    function automatic logic [N-1:0][DW-1:0] vec(input int i);
        return {DW'(32'hA0 + i), DW'(32'h50 + i)};
    endfunction
    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask
    task automatic capture(input int i);
        tracing = 1'b1;
        valid_in = 1'b1;
        vector_in = vec(i);
        tick();
        valid_in = 1'b0;
    endtask
    task automatic push(input int i, input logic l);
        q.push_back('{v: vec(i), l: l});
    endtask
    task automatic start_drain();
        tracing = 1'b0;
        drain_start = 1'b1;
        tick();
        drain_start = 1'b0;
    endtask
    task automatic wait_empty();
        int n = 0;
        while ((q.size() != 0 || valid_out) && n < 60) begin
            tick();
            n++;
        end
        chk("drain_timeout", 64'(n < 60), 64'd1);
    endtask
    always @(negedge clk) begin
        if (rst_n) begin
            if (held) begin
                chk("hold_vec", vector_out, held_v);
                chk("hold_valid", valid_out, 1);
            end
            if (valid_out && out_ready) begin
                if (q.size() == 0) begin
                    checks++;
                    fails++;
                    $display("FAIL unexpected_out: got %0h expected no output", vector_out);
                end else begin
                    e = q.pop_front();
                    chk("out_vec", vector_out, e.v);
                    chk("out_last", last_out, e.l);
                end
            end
            held <= valid_out && !out_ready;
            held_v <= vector_out;
        end else begin
            held <= 1'b0;
        end
    end
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
    initial begin
        tick(2);
        chk("rst_count", count, 0);
        chk("rst_valid", valid_out, 0);
        chk("rst_last", last_out, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_vector", vector_out, 0);
        chk("rst_dropped", dropped_count, 0);
        rst_n = 1'b1;
        tick();
        // basic capture and drain with latency check
        capture(1); capture(2); capture(3);
        chk("t1_count", count, 3);
        chk("t1_overflow", overflow, 0);
        push(1, 0); push(2, 0); push(3, 1);
        start_drain();
        chk("t1_lat0", valid_out, 0);
        tick();
        chk("t1_lat1", valid_out, 0);
        tick();
        chk("t1_lat2", valid_out, 1);
        wait_empty();
        chk("t1_end_count", count, 0);
        chk("t1_end_overflow", overflow, 0);
        chk("t1_end_last", last_out, 0);
        // overwrite when full
        for (int i = 10; i < 16; i++) capture(i);
        chk("t2_overflow", overflow, 1);
        chk("t2_count", count, 4);
        chk("t2_dropped", dropped_count, DROPS);
        for (int i = 12; i < 16; i++) push(i, i == 15);
        start_drain();
        wait_empty();
        chk("t2_end_count", count, 0);
        chk("t2_end_overflow", overflow, 0);
        chk("t2_end_dropped", dropped_count, 0);
        // stop-when-full
        tracing = 1'b0; configId = 8'd1; configData = 8'h01;
        tick();
        configId = 8'd0;
        tick();
        for (int i = 20; i < 26; i++) capture(i);
        chk("t3_overflow", overflow, 1);
        chk("t3_count", count, 4);
        chk("t3_dropped", dropped_count, DROPS);
        for (int i = 20; i < 24; i++) push(i, i == 23);
        start_drain();
        wait_empty();
        chk("t3_end_count", count, 0);
        // backpressure
        for (int i = 30; i < 33; i++) capture(i);
        for (int i = 30; i < 33; i++) push(i, i == 32);
        start_drain();
        tick();
        for (int i = 0; i < 8; i++) begin
            out_ready = (8'b1110_1001 >> i) & 8'd1;
            tick();
        end
        out_ready = 1'b1;
        wait_empty();
        chk("t4_end_count", count, 0);
        // drain with empty buffer
        tracing = 1'b0;
        drain_start = 1'b1;
        tick();
        drain_start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("t5_empty_novalid", valid_out, 0);
            tick();
        end
        // drain_start during a capture
        tracing = 1'b1; valid_in = 1'b1; vector_in = vec(40); drain_start = 1'b1;
        tick();
        valid_in = 1'b0; drain_start = 1'b0;
        chk("t5_cap_count", count, 1);
        tick(3);
        chk("t5_cap_novalid", valid_out, 0);
        capture(41);
        push(40, 0); push(41, 1);
        // config byte 1 arriving mid-drain
        tracing = 1'b0; configId = 8'd1; configData = 8'h00; drain_start = 1'b1;
        tick();
        drain_start = 1'b0;
        tick(2);
        chk("t5_cfg_count", count, 2);
        wait_empty();
        configId = 8'd0;
        tick();
        chk("t5_cfg_sb", q.size(), 0);
        // async reset mid-drain
        for (int i = 50; i < 54; i++) capture(i);
        push(50, 0); push(51, 0);
        start_drain();
        tick(4);
        chk("t6_pre_count", count, 2);
        #1 rst_n = 1'b0;
        #1;
        chk("t6_rst_valid", valid_out, 0);
        chk("t6_rst_count", count, 0);
        chk("t6_rst_last", last_out, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        tick();
        chk("t6_post_valid", valid_out, 0);
        capture(60);
        push(60, 1);
        start_drain();
        wait_empty();
        chk("t6_end_count", count, 0);
        chk("sb_empty", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
